uart_rx_param: RTL and testbench

UART_RX_PARAM -- requirements
Module: uart_rx_param

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_baud_tick.sv | 31 +++
 rtl/uart_rx_param.sv | 185 ++++++++++++++++++
 tb/tb_uart_rx_param.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, parity modes and default timing.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    // 50 MHz / 115200 baud / 16x oversampling
    localparam int unsigned DEF_CLK_DIV    = 27;
    localparam int unsigned DEF_OVERSAMPLE = 16;

    // Parity check given the XOR of the data bits and the received parity bit
    function automatic logic parity_error(input int unsigned mode,
                                          input logic        data_xor,
                                          input logic        par_bit);
        case (mode)
            PAR_EVEN: return data_xor ^ par_bit;
            PAR_ODD:  return ~(data_xor ^ par_bit);
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick: one-clk pulse every CLK_DIV clocks.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             wrap_c;

    assign wrap_c = (cnt_q == CNT_LAST);

    // Divider counter wraps CLK_DIV-1 -> 0; tick registered on the wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            tick  <= 1'b0;
        end else begin
            cnt_q <= wrap_c ? '0 : cnt_q + CNT_W'(1);
            tick  <= wrap_c;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parameterised oversampling UART receiver with a single-word holding register.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
    parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = PAR_NONE,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_perr,
    output logic                 rx_ferr,
    output logic                 rx_overrun
);

    localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W  = 4;

    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    logic [1:0] sync_q;
    logic       rxd_s;
    logic       tick;

    rx_state_t            state_q,    state_d;
    logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
    logic [BIT_W-1:0]     bit_idx_q,  bit_idx_d;
    logic [DATA_BITS-1:0] shreg_q,    shreg_d;
    logic                 par_q,      par_d;
    logic                 ferr_acc_q, ferr_acc_d;
    logic                 done_c;
    logic                 frame_ferr_c;
    logic                 frame_perr_c;

    // Two-flop synchroniser for the asynchronous line, reset to idle-high
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rxd};
        end
    end

    assign rxd_s = sync_q[1];

    uart_baud_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_baud_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // FSM and frame datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            bit_idx_q  <= '0;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            ferr_acc_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
            ferr_acc_q <= ferr_acc_d;
        end
    end

    // Next-state logic: every decision is taken on an oversample tick
    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        bit_idx_d    = bit_idx_q;
        shreg_d      = shreg_q;
        par_d        = par_q;
        ferr_acc_d   = ferr_acc_q;
        done_c       = 1'b0;
        frame_ferr_c = ferr_acc_q;

        if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (!rxd_s) begin
                        state_d    = ST_START;
                        tick_cnt_d = '0;
                        bit_idx_d  = '0;
                        ferr_acc_d = 1'b0;
                    end
                end
                ST_START: begin
                    // Mid start bit: a high line here was only a glitch
                    if (tick_cnt_q == TICK_MID) begin
                        tick_cnt_d = '0;
                        state_d    = rxd_s ? ST_IDLE : ST_DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
                ST_DATA: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        shreg_d    = {rxd_s, shreg_q[DATA_BITS-1:1]};
                        if (bit_idx_q == DATA_LAST) begin
                            bit_idx_d = '0;
                            state_d   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + BIT_W'(1);
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
                ST_PARITY: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        par_d      = rxd_s;
                        state_d    = ST_STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
                ST_STOP: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d   = '0;
                        frame_ferr_c = ferr_acc_q | ~rxd_s;
                        ferr_acc_d   = frame_ferr_c;
                        if (bit_idx_q == STOP_LAST) begin
                            bit_idx_d = '0;
                            state_d   = ST_IDLE;
                            done_c    = 1'b1;
                        end else begin
                            bit_idx_d = bit_idx_q + BIT_W'(1);
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign frame_perr_c = parity_error(PARITY, ^shreg_q, par_q);

    // Holding register: load on completion if free or drained this clk, else flag overrun
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_perr    <= 1'b0;
            rx_ferr    <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            rx_overrun <= 1'b0;
            if (done_c) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shreg_q;
                    rx_perr  <= frame_perr_c;
                    rx_ferr  <= frame_ferr_c;
                    rx_valid <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench: three receiver configurations (8N1, 8E1, 7O2) driven in parallel.
module tb_uart_rx_param;
    import uart_pkg::*;

    localparam int unsigned CLK_DIV  = 27;
    localparam int unsigned OS       = 16;
    localparam int unsigned BIT_CLKS = CLK_DIV * OS;

    typedef struct packed {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1, rst2;
    logic rxd0, rxd1, rxd2;
    logic rdy0, rdy1, rdy2;
    logic [7:0] d0, d1;
    logic [6:0] d2;
    logic v0, v1, v2, pe0, pe1, pe2, fe0, fe1, fe2, ov0, ov1, ov2;

    uart_rx_param #(.CLK_DIV(CLK_DIV), .OVERSAMPLE(OS), .DATA_BITS(8),
                    .PARITY(PAR_NONE), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst(rst0), .rxd(rxd0), .rx_data(d0), .rx_valid(v0),
        .rx_ready(rdy0), .rx_perr(pe0), .rx_ferr(fe0), .rx_overrun(ov0));

    uart_rx_param #(.CLK_DIV(CLK_DIV), .OVERSAMPLE(OS), .DATA_BITS(8),
                    .PARITY(PAR_EVEN), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .rst(rst1), .rxd(rxd1), .rx_data(d1), .rx_valid(v1),
        .rx_ready(rdy1), .rx_perr(pe1), .rx_ferr(fe1), .rx_overrun(ov1));

    uart_rx_param #(.CLK_DIV(CLK_DIV), .OVERSAMPLE(OS), .DATA_BITS(7),
                    .PARITY(PAR_ODD), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .rst(rst2), .rxd(rxd2), .rx_data(d2), .rx_valid(v2),
        .rx_ready(rdy2), .rx_perr(pe2), .rx_ferr(fe2), .rx_overrun(ov2));

    logic [8:0] mdat [3];
    logic       mv [3], mr [3], mpe [3], mfe [3], mov [3];

    assign mdat[0] = 9'(d0);
    assign mdat[1] = 9'(d1);
    assign mdat[2] = 9'(d2);
    assign mv[0] = v0;    assign mv[1] = v1;    assign mv[2] = v2;
    assign mr[0] = rdy0;  assign mr[1] = rdy1;  assign mr[2] = rdy2;
    assign mpe[0] = pe0;  assign mpe[1] = pe1;  assign mpe[2] = pe2;
    assign mfe[0] = fe0;  assign mfe[1] = fe1;  assign mfe[2] = fe2;
    assign mov[0] = ov0;  assign mov[1] = ov1;  assign mov[2] = ov2;

    exp_t q0 [$];
    exp_t q1 [$];
    exp_t q2 [$];

    int n_checks;
    int n_fail;
    int ovr_exp [3];
    int ovr_seen [3];

    logic       held_v [3];
    logic [8:0] held_d [3];
    logic       held_pe [3];
    logic       held_fe [3];
    exp_t       mon_e;

    bit bad0, bad1, bad2;
    int sel2;
    logic [1:0] sv2;

    function automatic void chk(input string name, input int k,
                                input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, k, act, exp);
        end
    endfunction

    function automatic int qsize(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t qpop(input int k);
        exp_t e;
        case (k)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
        return e;
    endfunction

    function automatic void qpush(input int k, input exp_t e);
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    // Inputs change 1 time unit after a rising edge
    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_line(input int k, input logic v);
        case (k)
            0:       rxd0 = v;
            1:       rxd1 = v;
            default: rxd2 = v;
        endcase
    endtask

    task automatic drive_bit(input int k, input logic v);
        set_line(k, v);
        wait_clks(BIT_CLKS);
    endtask

    // Serialise one frame and record the word the receiver should present
    task automatic send_frame(input int k, input logic [8:0] data, input int nbits,
                              input int pmode, input logic pbit, input int nstop,
                              input logic [1:0] stop_val, input int gap, input bit deliver);
        exp_t e;
        int   ones;
        ones   = 0;
        e.data = '0;
        for (int i = 0; i < nbits; i++) begin
            e.data[i] = data[i];
            if (data[i]) ones++;
        end
        if (pbit) ones++;
        if (pmode == 1)      e.perr = (ones % 2) != 0;
        else if (pmode == 2) e.perr = (ones % 2) == 0;
        else                 e.perr = 1'b0;
        e.ferr = !stop_val[0] || (nstop == 2 && !stop_val[1]);
        if (deliver) qpush(k, e);
        else         ovr_exp[k]++;

        drive_bit(k, 1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(k, data[i]);
        if (pmode != 0) drive_bit(k, pbit);
        for (int i = 0; i < nstop; i++) drive_bit(k, stop_val[i]);
        set_line(k, 1'b1);
        if (gap > 0) wait_clks(gap * BIT_CLKS);
    endtask

    // Monitor: pops the scoreboard on every accepted word, checks held words stay put
    initial begin
        for (int k = 0; k < 3; k++) begin
            held_v[k]   = 1'b0;
            held_d[k]   = '0;
            held_pe[k]  = 1'b0;
            held_fe[k]  = 1'b0;
            ovr_seen[k] = 0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (mov[k]) ovr_seen[k]++;
                if (mv[k] && held_v[k]) begin
                    chk("hold_data", k, 32'(mdat[k]), 32'(held_d[k]));
                    chk("hold_flags", k, 32'({mpe[k], mfe[k]}), 32'({held_pe[k], held_fe[k]}));
                end
                if (mv[k] && mr[k]) begin
                    if (qsize(k) == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_word[%0d]: got 0x%0h, expected no word", k, mdat[k]);
                    end else begin
                        mon_e = qpop(k);
                        chk("rx_data", k, 32'(mdat[k]), 32'(mon_e.data));
                        chk("rx_perr", k, 32'(mpe[k]), 32'(mon_e.perr));
                        chk("rx_ferr", k, 32'(mfe[k]), 32'(mon_e.ferr));
                    end
                    held_v[k] = 1'b0;
                end else if (mv[k]) begin
                    held_v[k]  = 1'b1;
                    held_d[k]  = mdat[k];
                    held_pe[k] = mpe[k];
                    held_fe[k] = mfe[k];
                end else begin
                    held_v[k] = 1'b0;
                end
            end
        end
    end

    // Stimulus
    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int k = 0; k < 3; k++) ovr_exp[k] = 0;
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        rxd0 = 1'b1; rxd1 = 1'b1; rxd2 = 1'b1;
        rdy0 = 1'b1; rdy1 = 1'b1; rdy2 = 1'b1;
        wait_clks(5);
        for (int k = 0; k < 3; k++) begin
            chk("rst_data", k, 32'(mdat[k]), 32'd0);
            chk("rst_valid", k, 32'(mv[k]), 32'd0);
            chk("rst_flags", k, 32'({mpe[k], mfe[k], mov[k]}), 32'd0);
        end
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
        wait_clks(3 * CLK_DIV);

        fork
            begin : line_8n1
                send_frame(0, 9'h0A5, 8, 0, 1'b0, 1, 2'b11, 1, 1'b1);
                // Short low pulse: must be rejected as a false start
                set_line(0, 1'b0);
                wait_clks(4 * CLK_DIV);
                set_line(0, 1'b1);
                wait_clks(2 * BIT_CLKS);
                chk("false_start_idle", 0, 32'(u_dut0.state_q), 32'(ST_IDLE));
                send_frame(0, 9'h055, 8, 0, 1'b0, 1, 2'b10, 2, 1'b1);
                // Back-pressure: second word is dropped with an overrun pulse
                rdy0 = 1'b0;
                send_frame(0, 9'h011, 8, 0, 1'b0, 1, 2'b11, 0, 1'b1);
                send_frame(0, 9'h022, 8, 0, 1'b0, 1, 2'b11, 1, 1'b0);
                wait_clks(50);
                rdy0 = 1'b1;
                wait_clks(1);
                chk("valid_drop", 0, 32'(v0), 32'd0);
                for (int i = 0; i < 4; i++) begin
                    bad0 = ($urandom_range(0, 3) == 0);
                    send_frame(0, 9'($urandom_range(0, 255)), 8, 0, 1'b0, 1,
                               bad0 ? 2'b10 : 2'b11, bad0 ? 2 : int'($urandom_range(0, 1)), 1'b1);
                end
            end
            begin : line_8e1
                send_frame(1, 9'h03C, 8, 1, 1'b1, 1, 2'b11, 1, 1'b1);
                send_frame(1, 9'h03C, 8, 1, 1'b0, 1, 2'b11, 1, 1'b1);
                for (int i = 0; i < 5; i++) begin
                    bad1 = ($urandom_range(0, 3) == 0);
                    send_frame(1, 9'($urandom_range(0, 255)), 8, 1, 1'($urandom_range(0, 1)), 1,
                               bad1 ? 2'b10 : 2'b11, bad1 ? 2 : int'($urandom_range(0, 1)), 1'b1);
                end
            end
            begin : line_7o2
                // Abort a frame part-way through its data bits
                drive_bit(2, 1'b0);
                for (int i = 0; i < 3; i++) drive_bit(2, 1'b1);
                rst2 = 1'b1;
                set_line(2, 1'b1);
                wait_clks(1);
                chk("abort_rst_valid", 2, 32'(v2), 32'd0);
                chk("abort_rst_data", 2, 32'(mdat[2]), 32'd0);
                wait_clks(2);
                rst2 = 1'b0;
                wait_clks(1);
                chk("abort_idle", 2, 32'(u_dut2.state_q), 32'(ST_IDLE));
                wait_clks(BIT_CLKS);
                send_frame(2, 9'h07F, 7, 2, 1'b0, 2, 2'b11, 1, 1'b1);
                for (int i = 0; i < 4; i++) begin
                    sel2 = int'($urandom_range(0, 5));
                    sv2  = (sel2 == 0) ? 2'b10 : (sel2 == 1) ? 2'b01 : 2'b11;
                    bad2 = (sv2 != 2'b11);
                    send_frame(2, 9'($urandom_range(0, 127)), 7, 2, 1'($urandom_range(0, 1)), 2,
                               sv2, bad2 ? 2 : int'($urandom_range(0, 1)), 1'b1);
                end
            end
        join

        for (int i = 0; i < 4 * int'(BIT_CLKS) && (q0.size() + q1.size() + q2.size()) != 0; i++)
            wait_clks(1);
        wait_clks(10);
        for (int k = 0; k < 3; k++) begin
            chk("leftover_words", k, 32'(qsize(k)), 32'd0);
            chk("overrun_pulses", k, 32'(ovr_seen[k]), 32'(ovr_exp[k]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
